// File: rtl/conv_seq_pkg.sv
// Shared types and helpers for the convolution / max-pool sequencer.
//   conv_seq_state_t : sequencer FSM states
//   out_dim(n,k)     : valid convolution output side (n-k+1)
//   pool_dim(m,p)    : pooled grid side (m/p)
//   idx_w(side)      : index width for a sweep of the given side (min 1 bit)
// Optional feature macro: CONV_SEQ_MAXPOOL_EN (pool sweep present).
package conv_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CONV,
    S_CFLUSH,
    S_POOL,
    S_PFLUSH
  } conv_seq_state_t;

  // LOAD and both FLUSH states are single-cycle
  localparam int LOAD_CYCLES  = 1;
  localparam int FLUSH_CYCLES = 1;

  function automatic int out_dim(int n, int k);
    return n - k + 1;
  endfunction

  function automatic int pool_dim(int m, int p);
    return m / p;
  endfunction

  function automatic int idx_w(int side);
    return (side > 1) ? $clog2(side) : 1;
  endfunction

endpackage

// File: rtl/idx2d_counter.sv
// Row-major 2D index sweep over a SIDE x SIDE grid.
//   clk, rst : clock, synchronous active-high reset
//   clr      : force indices back to (0,0)
//   en       : advance one position (column first, row on column wrap)
//   row, col : current position (registered)
//   last     : en while at (SIDE-1, SIDE-1)
// After the last position the indices wrap to (0,0), so they read 0
// whenever the sweep is not running.
module idx2d_counter
  import conv_seq_pkg::*;
#(
  parameter int SIDE = 8,
  localparam int W   = idx_w(SIDE)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] row,
  output logic [W-1:0] col,
  output logic         last
);

  localparam logic [W-1:0] MAX = W'(SIDE - 1);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      if (col == MAX) begin
        col <= '0;
        row <= (row == MAX) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  assign last = en && (row == MAX) && (col == MAX);

endmodule

// File: rtl/conv_sequencer.sv
// Control FSM for the 2D convolution / max-pool datapath.
//   clk, rst            : clock, synchronous active-high reset
//   start               : run request, honoured only while ready
//   ready / busy        : idle decode and its complement
//   in_sel              : image load select (LOAD cycle)
//   win_en, win_row/col : window evaluate enable and origin
//   wr_en, wr_row/col   : conv result write, one stage behind the window
//   out_sel             : result store routed to pooling (POOL..PFLUSH)
//   pool_en, pool_row/col, pool_wr_en : pool sweep and delayed write
//   conv_done, max_pool_done          : one-cycle completion pulses
// Macro CONV_SEQ_MAXPOOL_EN enables the pool sweep; otherwise the pool
// outputs are tied low and CFLUSH returns straight to IDLE.
module conv_sequencer
  import conv_seq_pkg::*;
#(
  parameter int N    = 10,
  parameter int K    = 3,
  parameter int POOL = 2
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start,
  output logic                                        ready,
  output logic                                        busy,
  output logic                                        in_sel,
  output logic                                        win_en,
  output logic [idx_w(out_dim(N,K))-1:0]              win_row,
  output logic [idx_w(out_dim(N,K))-1:0]              win_col,
  output logic                                        wr_en,
  output logic [idx_w(out_dim(N,K))-1:0]              wr_row,
  output logic [idx_w(out_dim(N,K))-1:0]              wr_col,
  output logic                                        out_sel,
  output logic                                        pool_en,
  output logic [idx_w(pool_dim(out_dim(N,K),POOL))-1:0] pool_row,
  output logic [idx_w(pool_dim(out_dim(N,K),POOL))-1:0] pool_col,
  output logic                                        pool_wr_en,
  output logic                                        conv_done,
  output logic                                        max_pool_done
);

  localparam int M = out_dim(N, K);
  localparam int P = pool_dim(M, POOL);

  conv_seq_state_t state, next_state;
  logic conv_last;
  logic pool_last;

  // Window sweep: cleared in LOAD, advances every CONV cycle
  idx2d_counter #(.SIDE(M)) u_conv_idx (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == S_LOAD),
    .en   (state == S_CONV),
    .row  (win_row),
    .col  (win_col),
    .last (conv_last)
  );

`ifdef CONV_SEQ_MAXPOOL_EN
  idx2d_counter #(.SIDE(P)) u_pool_idx (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == S_CFLUSH),
    .en   (state == S_POOL),
    .row  (pool_row),
    .col  (pool_col),
    .last (pool_last)
  );
`else
  assign pool_row  = '0;
  assign pool_col  = '0;
  assign pool_last = 1'b0;
`endif

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (start) next_state = S_LOAD;
      S_LOAD:   next_state = S_CONV;
      S_CONV:   if (conv_last) next_state = S_CFLUSH;
`ifdef CONV_SEQ_MAXPOOL_EN
      S_CFLUSH: next_state = S_POOL;
      S_POOL:   if (pool_last) next_state = S_PFLUSH;
      S_PFLUSH: next_state = S_IDLE;
`else
      S_CFLUSH: next_state = S_IDLE;
`endif
      default:  next_state = S_IDLE;
    endcase
  end

  // Strobes are decoded from next_state so they are registered yet line
  // up with the state they describe. The write stage is a one-deep delay
  // of the evaluate stage to cover the MAC latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      in_sel    <= 1'b0;
      win_en    <= 1'b0;
      wr_en     <= 1'b0;
      wr_row    <= '0;
      wr_col    <= '0;
      conv_done <= 1'b0;
    end else begin
      state     <= next_state;
      in_sel    <= (next_state == S_LOAD);
      win_en    <= (next_state == S_CONV);
      wr_en     <= win_en;
      wr_row    <= win_row;
      wr_col    <= win_col;
      conv_done <= (next_state == S_CFLUSH);
    end
  end

`ifdef CONV_SEQ_MAXPOOL_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      out_sel       <= 1'b0;
      pool_en       <= 1'b0;
      pool_wr_en    <= 1'b0;
      max_pool_done <= 1'b0;
    end else begin
      out_sel       <= (next_state == S_POOL) || (next_state == S_PFLUSH);
      pool_en       <= (next_state == S_POOL);
      pool_wr_en    <= pool_en;
      max_pool_done <= (next_state == S_PFLUSH);
    end
  end
`else
  assign out_sel       = 1'b0;
  assign pool_en       = 1'b0;
  assign pool_wr_en    = 1'b0;
  assign max_pool_done = 1'b0;
`endif

  assign ready = (state == S_IDLE);
  assign busy  = ~ready;

endmodule
